// File: rtl/mmio_uart_tx_pkg.sv
// Shared definitions for the memory-mapped UART transmitter:
// register offsets, STATUS bit positions and serializer state encoding.
package mmio_uart_tx_pkg;

  localparam logic [1:0] REG_TXDATA = 2'd0;
  localparam logic [1:0] REG_STATUS = 2'd1;
  localparam logic [1:0] REG_COUNT  = 2'd2;

  localparam int STAT_EMPTY = 0;
  localparam int STAT_FULL  = 1;
  localparam int STAT_BUSY  = 2;
  localparam int STAT_OVF   = 3;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_START = 2'd1,
    S_DATA  = 2'd2,
    S_STOP  = 2'd3
  } tx_state_e;

endpackage

// File: rtl/mmio_uart_tx_if.sv
// Data-memory bus as seen from the MEM stage: address, write data,
// write strobe, and the combinational read data / hit returned by a peripheral.
interface mmio_uart_tx_if;
  logic [7:0] addr;
  logic [7:0] wdata;
  logic       we;
  logic [7:0] rdata;
  logic       hit;

  modport master (output addr, wdata, we, input rdata, hit);
  modport slave  (input addr, wdata, we, output rdata, hit);
endinterface

// File: rtl/mmio_uart_tx_sync_fifo.sv
// Single-clock FIFO with show-ahead output; pushes while full and pops
// while empty are ignored. Synchronous active-low reset.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  logic                     push_i,
  input  logic                     pop_i,
  input  logic [WIDTH-1:0]         din_i,
  output logic [WIDTH-1:0]         dout_o,
  output logic                     empty_o,
  output logic                     full_o,
  output logic [$clog2(DEPTH):0]   count_o
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wptr_q, rptr_q;
  logic [AW:0]      count_q;
  logic             push_ok, pop_ok;

  assign empty_o = (count_q == '0);
  assign full_o  = (count_q == (AW+1)'(DEPTH));
  assign count_o = count_q;
  assign dout_o  = mem_q[rptr_q];
  assign push_ok = push_i && !full_o;
  assign pop_ok  = pop_i && !empty_o;

  always_ff @(posedge clk_i) begin
    if (push_ok) mem_q[wptr_q] <= din_i;
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
    end else begin
      if (push_ok) wptr_q <= wptr_q + AW'(1);
      if (pop_ok)  rptr_q <= rptr_q + AW'(1);
      case ({push_ok, pop_ok})
        2'b10:   count_q <= count_q + (AW+1)'(1);
        2'b01:   count_q <= count_q - (AW+1)'(1);
        default: count_q <= count_q;
      endcase
    end
  end

endmodule

// File: rtl/mmio_uart_tx.sv
// Memory-mapped 8N1 UART transmitter: address decode, register read mux,
// sticky overflow flag, TX FIFO and the bit serializer.
module mmio_uart_tx
  import mmio_uart_tx_pkg::*;
#(
  parameter logic [7:0] BASE_ADDR    = 8'hF0,
  parameter int         CLKS_PER_BIT = 868,
  parameter int         FIFO_DEPTH   = 4
) (
  input  logic            clk_i,
  input  logic            reset_ni,
  mmio_uart_tx_if.slave   bus,
  output logic            tx_o,
  output logic            tx_busy_o
);

  localparam int          CW        = $clog2(FIFO_DEPTH) + 1;
  localparam logic [15:0] BAUD_LAST = 16'(CLKS_PER_BIT - 1);

  logic [7:0]    offset;
  logic [1:0]    reg_sel;
  logic          push, pop, ovf_clr;
  logic          fifo_empty, fifo_full;
  logic [7:0]    fifo_dout;
  logic [CW-1:0] fifo_count;
  logic [7:0]    status;
  logic          ovf_q;

  tx_state_e     state_q, state_d;
  logic [15:0]   baud_q, baud_d;
  logic [2:0]    bit_q, bit_d;
  logic [7:0]    shift_q, shift_d;
  logic          tx_q, tx_d;
  logic          busy_q;

  // Offset arithmetic keeps the window check correct for any BASE_ADDR.
  assign offset  = bus.addr - BASE_ADDR;
  assign bus.hit = (offset < 8'd4);
  assign reg_sel = offset[1:0];
  assign push    = bus.hit && bus.we && (reg_sel == REG_TXDATA);
  assign ovf_clr = bus.hit && bus.we && (reg_sel == REG_STATUS);

  always_comb begin
    status             = '0;
    status[STAT_EMPTY] = fifo_empty;
    status[STAT_FULL]  = fifo_full;
    status[STAT_BUSY]  = busy_q;
    status[STAT_OVF]   = ovf_q;
  end

  always_comb begin
    bus.rdata = 8'h00;
    if (bus.hit) begin
      case (reg_sel)
        REG_STATUS: bus.rdata = status;
        REG_COUNT:  bus.rdata = 8'(fifo_count);
        default:    bus.rdata = 8'h00;
      endcase
    end
  end

  sync_fifo #(.WIDTH(8), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk_i   (clk_i),
    .rst_ni  (reset_ni),
    .push_i  (push),
    .pop_i   (pop),
    .din_i   (bus.wdata),
    .dout_o  (fifo_dout),
    .empty_o (fifo_empty),
    .full_o  (fifo_full),
    .count_o (fifo_count)
  );

  always_ff @(posedge clk_i) begin
    if (!reset_ni)                ovf_q <= 1'b0;
    else if (push && fifo_full)   ovf_q <= 1'b1;
    else if (ovf_clr)             ovf_q <= 1'b0;
  end

  always_ff @(posedge clk_i) begin
    if (!reset_ni) begin
      state_q <= S_IDLE;
      baud_q  <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      tx_q    <= 1'b1;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      baud_q  <= baud_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      tx_q    <= tx_d;
      busy_q  <= (state_d != S_IDLE);
    end
  end

  always_comb begin
    state_d = state_q;
    baud_d  = baud_q;
    bit_d   = bit_q;
    shift_d = shift_q;
    pop     = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (!fifo_empty) begin
          pop     = 1'b1;
          shift_d = fifo_dout;
          bit_d   = '0;
          baud_d  = BAUD_LAST;
          state_d = S_START;
        end
      end
      S_START: begin
        if (baud_q == '0) begin
          baud_d  = BAUD_LAST;
          state_d = S_DATA;
        end else begin
          baud_d = baud_q - 16'd1;
        end
      end
      S_DATA: begin
        if (baud_q == '0) begin
          baud_d  = BAUD_LAST;
          shift_d = {1'b0, shift_q[7:1]};
          bit_d   = bit_q + 3'd1;
          if (bit_q == 3'd7) state_d = S_STOP;
        end else begin
          baud_d = baud_q - 16'd1;
        end
      end
      S_STOP: begin
        if (baud_q == '0) begin
          // Chain straight into the next start bit when data is waiting.
          if (!fifo_empty) begin
            pop     = 1'b1;
            shift_d = fifo_dout;
            bit_d   = '0;
            baud_d  = BAUD_LAST;
            state_d = S_START;
          end else begin
            state_d = S_IDLE;
          end
        end else begin
          baud_d = baud_q - 16'd1;
        end
      end
      default: state_d = S_IDLE;
    endcase

    case (state_d)
      S_START: tx_d = 1'b0;
      S_DATA:  tx_d = shift_d[0];
      default: tx_d = 1'b1;
    endcase
  end

  assign tx_o      = tx_q;
  assign tx_busy_o = busy_q;

endmodule

// File: doc/mmio_uart_tx.md
# mmio_uart_tx

Memory-mapped UART transmitter peripheral that responds to the CPU's data-memory bus, the same addr/data/WE/read_data bus the MEM stage drives. CPU stores to the data register push bytes into a small FIFO. A serializer drains the FIFO onto a single 8N1 serial line. The block decodes its own address window and sits beside the data memory, with its read data muxed into the MEM-stage load path.

## Interface
- BASE_ADDR, 8'hF0: first of 4 consecutive byte addresses owned by the block.
- CLKS_PER_BIT, 868: clock cycles per serial bit (100 MHz / 115200). Legal range is 2..65535.
- FIFO_DEPTH, 4: TX FIFO entries. Must be a power of 2, minimum 2.

Ports:
- clk, input, 1: rising-edge clock.
- reset, input, 1: synchronous, active-low reset.
- addr, input, 8: bus address from the MEM stage.
- data, input, 8: bus write data.
- WE, input, 1: bus write strobe, sampled on the clk edge.
- read_data, output, 8: combinational read data. Forced to 8'h00 when `hit`=0.
- hit, output, 1: combinational, 1 when addr is in BASE_ADDR..BASE_ADDR+3.
- tx, output, 1: serial output, idle high.
- tx_busy, output, 1: registered. 1 while the FSM is outside IDLE.

## Operation
Register map (offset from BASE_ADDR):
- +0 TXDATA. A write pushes `data` into the FIFO. Reads return 8'h00.
- +1 STATUS. Read bits: [0] fifo_empty, [1] fifo_full, [2] tx_busy, [3] overflow (sticky), [7:4] = 0. A write of any value clears overflow.
- +2 COUNT. Read returns FIFO occupancy, zero-extended to 8 bits. Writes are ignored.
- +3 reserved. Reads 8'h00; writes are ignored.

FIFO rules:
- A push to TXDATA while fifo_full is dropped and sets overflow. This holds even if a pop happens in the same cycle; fullness is evaluated before the edge.
- If a pop and an accepted push happen in the same cycle, count is unchanged.
- Read and write pointers are log2(FIFO_DEPTH) bits and wrap naturally. Count is log2(FIFO_DEPTH)+1 bits.

Serializer FSM:
- States: IDLE, START, DATA, STOP.
- IDLE: tx=1. If the FIFO is not empty, pop into shift_reg, clear bit_cnt, load baud_cnt=CLKS_PER_BIT-1, and go to START.
- START: tx=0 for CLKS_PER_BIT cycles, then go to DATA.
- DATA: tx=shift_reg[0], LSB first. When baud_cnt reaches 0: shift right and increment bit_cnt. After the 8th bit, go to STOP.
- STOP: tx=1 for CLKS_PER_BIT cycles. At the end, pop and go to START if the FIFO is not empty (no idle gap); otherwise go to IDLE.
- baud_cnt counts down from CLKS_PER_BIT-1 to 0. Its width is 16 bits.

Reset:
- Reset takes priority over everything, including a bus write in the same cycle.
- It empties the FIFO, clears overflow, forces IDLE, and drives tx=1 and tx_busy=0.
- Asserting reset mid-frame truncates the frame immediately. The line returns high on the next edge, with no partial stop bit.
- Reset values: tx=1, tx_busy=0, and STATUS reads 8'h01.

## Timing
- Cycle N: TXDATA write with the FIFO empty and the FSM idle. After edge N, fifo_empty=0 and COUNT=1.
- Edge N+1: pop, FSM goes to START. tx=0 and tx_busy=1 from N+1, and COUNT returns to 0.
- Frame length is exactly 10*CLKS_PER_BIT cycles from the tx falling edge to the end of the stop bit.
- Back-to-back frames are contiguous: the next start bit begins the cycle after the stop bit ends.
- read_data and hit are purely combinational from addr and current state, with zero latency, matching the data-memory read path.
- STATUS and COUNT reflect register state before the current edge. A write and a read in the same cycle return the old value.
- tx is driven directly from a flop: no combinational path from the bus to tx.

## Structure
- Shared header `mmio_defs.vh` holds:
  - register offsets REG_TXDATA=0, REG_STATUS=1, REG_COUNT=2;
  - STATUS bit indices;
  - FSM state encodings S_IDLE, S_START, S_DATA, S_STOP (2-bit).
- Sub-module `sync_fifo` (parameters WIDTH, DEPTH):
  - ports push, pop, din, dout, empty, full, count;
  - a pop while empty is ignored.
- The top level contains the address decode, register read mux, overflow flop and the serializer FSM.

## Test plan
Bench uses CLKS_PER_BIT=4, FIFO_DEPTH=4, BASE_ADDR=8'hF0.

1. Reset:
   - Release reset with no bus activity. Expect tx=1 and tx_busy=0, and addr=F1 reads 8'h01.
   - Set addr=F4. Expect hit=0 and read_data=8'h00.
2. Single byte:
   - Write 8'hA5 to F0.
   - Expect tx low 4 cycles, then 1,0,1,0,0,1,0,1 at 4 cycles each, then high 4 cycles.
   - Expect tx_busy to drop after exactly 40 cycles.
3. Back-to-back:
   - Write 8'h01 then 8'h80 on consecutive cycles.
   - Expect two 40-cycle frames with no high gap between stop and start, and COUNT reading 1 then 0.
4. Overflow:
   - Write 6 bytes on consecutive cycles while idle. Byte 1 is popped immediately, 4 are queued, and byte 6 is dropped.
   - Expect STATUS=8'h0E (full, busy, overflow).
   - Write 0 to F1. Expect STATUS bit3=0.
5. Mid-frame reset:
   - Assert reset during DATA bit 3 of a frame, with 2 bytes queued.
   - Expect tx=1 the next cycle, COUNT=0, no further frames, and STATUS=8'h01.
6. Reset vs write:
   - Write F0 in the same cycle reset is asserted. Expect COUNT=0 and no frame transmitted.
